// File: rtl/pipelined_dr_alm.sv
// Pipelined dynamic-range approximate log multiplier (DR-ALM).
// Three stages: S1 abs/leading-one/normalise, S2 mantissa add + compensation
// (and the exact product), S3 antilog + sign. One global advance enable gives
// full backpressure with a capacity of three operations.
module pipelined_dr_alm #(
    parameter int WIDTH     = 16,
    parameter int M_WIDTH   = 10,
    parameter int COMP_KMIN = 3,
    parameter int TAG_WIDTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [WIDTH-1:0]       i_a,
    input  logic [WIDTH-1:0]       i_b,
    input  logic                   i_exact,
    input  logic                   i_comp_en,
    input  logic [TAG_WIDTH-1:0]   i_tag,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [2*WIDTH-1:0]     o_z,
    output logic [TAG_WIDTH-1:0]   o_tag
);

    localparam int F  = WIDTH - 1;
    localparam int R  = F - M_WIDTH;
    localparam int KW = $clog2(WIDTH);
    localparam int ZW = 2 * WIDTH;
    // wide enough that the carry-doubled mantissa shifted by K never overflows
    localparam int MW = 2 * WIDTH + M_WIDTH + 1;

    function automatic logic [KW-1:0] lod(input logic [WIDTH-1:0] x);
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (x[i]) k = KW'(i);
        end
        return k;
    endfunction

    logic                  w_en;
    logic [WIDTH-1:0]      w_abs_a, w_abs_b;
    logic [KW-1:0]         w_k_a, w_k_b;
    logic [M_WIDTH-1:0]    w_ft_a, w_ft_b;
    logic                  w_comp;
    logic [M_WIDTH:0]      w_sum;
    logic [MW-1:0]         w_mant;
    logic [ZW-1:0]         w_approx, w_mag, w_z;

    logic                  r_v1, r_v2, r_v3;
    logic                  r_neg1, r_zero1, r_ex1, r_ce1;
    logic [WIDTH-1:0]      r_abs_a1, r_abs_b1;
    logic [KW-1:0]         r_k_a1, r_k_b1;
    logic [M_WIDTH-1:0]    r_ft_a1, r_ft_b1;
    logic [TAG_WIDTH-1:0]  r_tag1, r_tag2, r_tag3;
    logic                  r_neg2, r_zero2, r_ex2;
    logic [M_WIDTH:0]      r_sum2;
    logic [KW:0]           r_kk2;
    logic [ZW-1:0]         r_prod2, r_z3;

    assign w_en    = !r_v3 || i_ready;
    assign o_ready = w_en;
    assign o_valid = r_v3;
    assign o_z     = r_z3;
    assign o_tag   = r_tag3;

    // S1 combinational: magnitude, leading-one index, kept mantissa bits
    always_comb begin
        w_abs_a = i_a[WIDTH-1] ? -i_a : i_a;
        w_abs_b = i_b[WIDTH-1] ? -i_b : i_b;
        w_k_a   = lod(w_abs_a);
        w_k_b   = lod(w_abs_b);
        // normalise leading one to bit F; the cast drops it and keeps frac[F-1:R]
        w_ft_a  = M_WIDTH'((w_abs_a << (F - w_k_a)) >> R);
        w_ft_b  = M_WIDTH'((w_abs_b << (F - w_k_b)) >> R);
    end

    // S2 combinational: compensated mantissa sum
    always_comb begin
        w_comp = r_ce1 && (R > 0) && (int'(r_k_a1) >= COMP_KMIN) && (int'(r_k_b1) >= COMP_KMIN);
        w_sum  = (M_WIDTH+1)'(r_ft_a1) + (M_WIDTH+1)'(r_ft_b1) + (M_WIDTH+1)'(w_comp);
    end

    // S3 combinational: antilog with carry honoured, mode select, sign
    always_comb begin
        w_mant   = r_sum2[M_WIDTH] ? (MW'(r_sum2) << 1)
                                   : ((MW'(1) << M_WIDTH) + MW'(r_sum2));
        w_approx = ZW'((w_mant << r_kk2) >> M_WIDTH);
        w_mag    = r_zero2 ? '0 : (r_ex2 ? r_prod2 : w_approx);
        w_z      = r_neg2 ? -w_mag : w_mag;
    end

    // stage valid bits and the visible output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_v3   <= 1'b0;
            r_z3   <= '0;
            r_tag3 <= '0;
        end else if (w_en) begin
            r_v1   <= i_valid;
            r_v2   <= r_v1;
            r_v3   <= r_v2;
            r_z3   <= w_z;
            r_tag3 <= r_tag2;
        end
    end

    // S1 payload capture; mode bits and tag ride along with the operands
    always_ff @(posedge i_clk) begin
        if (w_en) begin
            r_abs_a1 <= w_abs_a;
            r_abs_b1 <= w_abs_b;
            r_k_a1   <= w_k_a;
            r_k_b1   <= w_k_b;
            r_ft_a1  <= w_ft_a;
            r_ft_b1  <= w_ft_b;
            r_neg1   <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
            r_zero1  <= (w_abs_a == '0) || (w_abs_b == '0);
            r_ex1    <= i_exact;
            r_ce1    <= i_comp_en;
            r_tag1   <= i_tag;
        end
    end

    // S2 payload capture, including the exact product for exact-mode ops
    always_ff @(posedge i_clk) begin
        if (w_en) begin
            r_sum2  <= w_sum;
            r_kk2   <= {1'b0, r_k_a1} + {1'b0, r_k_b1};
            r_prod2 <= ZW'(r_abs_a1) * ZW'(r_abs_b1);
            r_neg2  <= r_neg1;
            r_zero2 <= r_zero1;
            r_ex2   <= r_ex1;
            r_tag2  <= r_tag1;
        end
    end

endmodule
